// File: rtl/jtoutrun_pkg.sv
// Shared object-layer definitions: pixel word layout, special colours and
// the draw-side priority/shadow merge rule.
package jtoutrun_pkg;

  localparam int OBJ_DW = 14;
  localparam int OBJ_AW = 9;

  // Pixel word: {prio[13:12], shadow[11], pal[10:4], colour[3:0]}
  localparam int PRIO_HI    = 13;
  localparam int PRIO_LO    = 12;
  localparam int SHADOW_BIT = 11;
  localparam int COL_HI     = 3;
  localparam int COL_LO     = 0;

  localparam logic [3:0] COL_TRANSP = 4'h0;
  localparam logic [3:0] COL_SHADOW = 4'hA;

  typedef logic [OBJ_DW-1:0] obj_word_t;

  // Result of placing new pixel nw over stored pixel st.
  // A shadow pixel only darkens something already drawn.
  function automatic obj_word_t obj_merge(input obj_word_t nw, input obj_word_t st);
    obj_word_t r;
    r = st;
    if (nw[SHADOW_BIT] && nw[COL_HI:COL_LO] == COL_SHADOW) begin
      if (st[COL_HI:COL_LO] != COL_TRANSP) r[SHADOW_BIT] = 1'b1;
    end else if (st[COL_HI:COL_LO] == COL_TRANSP ||
                 nw[PRIO_HI:PRIO_LO] >= st[PRIO_HI:PRIO_LO]) begin
      r = nw;
    end
    return r;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 registered read, port 1 write.
// A same-cycle read of the address being written returns the old word.
module jtframe_dual_ram #(
  parameter int DW = 14,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] addr0_i,
  output logic [DW-1:0] q0_o,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] data1_i,
  input  logic          we1_i
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] q0_q;

  always_ff @(posedge clk) begin
    q0_q <= mem_q[addr0_i];
    if (we1_i) mem_q[addr1_i] <= data1_i;
  end

  assign q0_o = q0_q;

endmodule

// File: rtl/jtoutrun_obj_lbuf.sv
// Double-buffered object line buffer: one bank is drawn with a 2-cycle
// priority RMW while the other is scanned out and erased behind the beam.
module jtoutrun_obj_lbuf
  import jtoutrun_pkg::*;
#(
  parameter logic [8:0] PXL_DLY = 9'd8,
  parameter logic [8:0] HSTART  = 9'haa
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        flip,
  input  logic [8:0]  wr_addr,
  input  logic [13:0] wr_data,
  input  logic        wr_we,
  output logic [13:0] pxl
);

  localparam logic [8:0] HOBJ_START = HSTART - PXL_DLY;
  localparam logic [8:0] HOBJ_FLIP  = 9'h1ff + (9'hc0 - HOBJ_START);

  // bank_q names the draw bank; the other bank is on display
  logic              lhbl_q;
  logic              bank_q, bank_d;
  logic [8:0]        hobj_q, hobj_d;

  logic              s1_valid_q;
  logic [8:0]        s1_addr_q;
  obj_word_t         s1_data_q;
  logic              s1_bank_q;
  logic              fwd_valid_q;
  obj_word_t         fwd_data_q;

  logic              rd_valid_q;
  logic [8:0]        rd_addr_q;
  logic              rd_bank_q;
  obj_word_t         pxl_q, pxl_d;

  logic              wr_accept;
  logic              disp_rd;
  logic              fwd_hit;
  obj_word_t         stored;
  obj_word_t         merged;
  obj_word_t         ram_q [2];

  assign wr_accept = wr_we && (wr_data[COL_HI:COL_LO] != COL_TRANSP);
  assign disp_rd   = pxl_cen && LHBL;

  // A back-to-back hit on the same word reads stale RAM; use the word
  // committed in the previous cycle instead.
  assign fwd_hit = s1_valid_q && wr_accept && (wr_addr == s1_addr_q) && (bank_q == s1_bank_q);
  assign stored  = fwd_valid_q ? fwd_data_q : ram_q[s1_bank_q];
  assign merged  = obj_merge(s1_data_q, stored);

  always_comb begin
    bank_d = bank_q;
    if (lhbl_q && !LHBL) bank_d = ~bank_q;

    hobj_d = hobj_q;
    if (!LHBL)        hobj_d = flip ? HOBJ_FLIP : HOBJ_START;
    else if (pxl_cen) hobj_d = flip ? hobj_q - 9'd1 : hobj_q + 9'd1;

    pxl_d = pxl_q;
    if (!LHBL)           pxl_d = '0;
    else if (rd_valid_q) pxl_d = ram_q[rd_bank_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhbl_q      <= 1'b0;
      bank_q      <= 1'b0;
      hobj_q      <= HOBJ_START;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      s1_bank_q   <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      pxl_q       <= '0;
    end else begin
      lhbl_q      <= LHBL;
      bank_q      <= bank_d;
      hobj_q      <= hobj_d;
      s1_valid_q  <= wr_accept;
      s1_addr_q   <= wr_addr;
      s1_data_q   <= wr_data;
      s1_bank_q   <= bank_q;
      fwd_valid_q <= fwd_hit;
      fwd_data_q  <= merged;
      rd_valid_q  <= disp_rd;
      rd_addr_q   <= hobj_q;
      rd_bank_q   <= ~bank_q;
      pxl_q       <= pxl_d;
    end
  end

  assign pxl = pxl_q;

  // Commit and erase never target the same bank: each carries the bank
  // it was issued against, so a swap mid-flight cannot collide them.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic       is_draw;
    logic       commit;
    logic       erase;
    logic [8:0] rd_addr_b;
    logic [8:0] wr_addr_b;
    obj_word_t  wr_data_b;

    assign is_draw   = (bank_q == 1'(gi));
    assign commit    = s1_valid_q && (s1_bank_q == 1'(gi));
    assign erase     = rd_valid_q && (rd_bank_q == 1'(gi));
    assign rd_addr_b = is_draw ? wr_addr : hobj_q;
    assign wr_addr_b = commit ? s1_addr_q : rd_addr_q;
    assign wr_data_b = commit ? merged : '0;

    jtframe_dual_ram #(
      .DW (OBJ_DW),
      .AW (OBJ_AW)
    ) u_ram (
      .clk     (clk),
      .addr0_i (rd_addr_b),
      .q0_o    (ram_q[gi]),
      .addr1_i (wr_addr_b),
      .data1_i (wr_data_b),
      .we1_i   (commit || erase)
    );
  end

endmodule

// File: tb/tb_jtoutrun_obj_lbuf.sv
// Directed bench for the object line buffer: table of draw scenarios
// plus hand sequences for erase, clock-enable hold, flip and reset.
module tb_jtoutrun_obj_lbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen;
  logic        LHBL;
  logic        flip;
  logic [8:0]  wr_addr;
  logic [13:0] wr_data;
  logic        wr_we;
  logic [13:0] pxl;

  localparam logic [8:0] START_N = 9'haa - 9'd8;
  localparam logic [8:0] START_F = 9'h1ff + (9'hc0 - 9'ha2);

  int checks   = 0;
  int failures = 0;
  int hold_err;

  logic [13:0] disp     [512];
  logic [13:0] slot_val [513];

  jtoutrun_obj_lbuf dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .LHBL    (LHBL),
    .flip    (flip),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_we   (wr_we),
    .pxl     (pxl)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        flipv;
    int          nwr;
    logic [8:0]  a0;
    logic [13:0] d0;
    logic [8:0]  a1;
    logic [13:0] d1;
    int          gap;
    logic [8:0]  chk;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic blank(input int n);
    LHBL = 1'b0;
    pxl_cen = 1'b1;
    cyc(n);
  endtask

  task automatic wr(input logic [8:0] a, input logic [13:0] d);
    wr_addr = a;
    wr_data = d;
    wr_we   = 1'b1;
    cyc(1);
    wr_we   = 1'b0;
  endtask

  // Scan one line of 513 reads; disp[] is indexed by the x the bench
  // expects at each slot, slot_val[] by read order.
  task automatic run_line(input int cen_div);
    logic [8:0]  a;
    logic [8:0]  pend;
    int          pend_slot;
    logic        pend_v;
    logic        cur_cen;
    logic        have;
    logic [13:0] last;
    int          reads;
    int          n;
    a = flip ? START_F : START_N;
    reads = 0; pend_v = 1'b0; have = 1'b0; last = '0; n = 0;
    pend = '0; pend_slot = 0; hold_err = 0;
    LHBL = 1'b1;
    while (reads < 513) begin
      pxl_cen = ((n % cen_div) == 0);
      cur_cen = pxl_cen;
      cyc(1);
      if (pend_v) begin
        disp[pend] = pxl;
        slot_val[pend_slot] = pxl;
        last = pxl;
        have = 1'b1;
      end else if (have && pxl !== last) begin
        hold_err++;
      end
      if (cur_cen) begin
        pend = a; pend_slot = reads; pend_v = 1'b1;
        a = flip ? a - 9'd1 : a + 9'd1;
        reads++;
      end else begin
        pend_v = 1'b0;
      end
      n++;
    end
    pxl_cen = 1'b1;
    LHBL = 1'b0;
  endtask

  function automatic int count_nonzero(input logic [8:0] e0, input logic [8:0] e1);
    int nz = 0;
    for (int i = 0; i < 512; i++)
      if (9'(i) != e0 && 9'(i) != e1 && disp[i] !== 14'd0) nz++;
    return nz;
  endfunction

  initial begin
    vecs[0]  = '{"single_x20",   1'b0, 1, 9'd20,  14'h1235, 9'd0,  14'h0000, 0, 9'd20,  14'h1235};
    vecs[1]  = '{"prio_keep",    1'b0, 2, 9'd30,  14'h2003, 9'd30, 14'h1007, 2, 9'd30,  14'h2003};
    vecs[2]  = '{"b2b_lo_hi",    1'b0, 2, 9'd40,  14'h1004, 9'd40, 14'h3009, 0, 9'd40,  14'h3009};
    vecs[3]  = '{"b2b_hi_lo",    1'b0, 2, 9'd40,  14'h3009, 9'd40, 14'h1004, 0, 9'd40,  14'h3009};
    vecs[4]  = '{"col0_drop",    1'b0, 1, 9'd50,  14'h1230, 9'd0,  14'h0000, 0, 9'd50,  14'h0000};
    vecs[5]  = '{"col0_keep",    1'b0, 2, 9'd50,  14'h1006, 9'd50, 14'h3000, 1, 9'd50,  14'h1006};
    vecs[6]  = '{"shadow",       1'b0, 2, 9'd50,  14'h1006, 9'd50, 14'h080A, 2, 9'd50,  14'h1806};
    vecs[7]  = '{"shadow_b2b",   1'b0, 2, 9'd55,  14'h1006, 9'd55, 14'h080A, 0, 9'd55,  14'h1806};
    vecs[8]  = '{"prio_equal",   1'b0, 2, 9'd60,  14'h2003, 9'd60, 14'h2055, 0, 9'd60,  14'h2055};
    vecs[9]  = '{"b2b_diffaddr", 1'b0, 2, 9'd70,  14'h3009, 9'd71, 14'h1004, 0, 9'd71,  14'h1004};
    vecs[10] = '{"flip_x100",    1'b1, 1, 9'd100, 14'h1111, 9'd0,  14'h0000, 0, 9'd100, 14'h1111};

    rst = 1'b1; pxl_cen = 1'b1; LHBL = 1'b0; flip = 1'b0;
    wr_addr = '0; wr_data = '0; wr_we = 1'b0;
    cyc(4);
    check("reset_pxl", 32'(pxl), 32'h0);
    rst = 1'b0;

    // Flush stale RAM contents out of both banks
    blank(4); run_line(1); blank(6); run_line(1);
    blank(4);
    check("blank_pxl_zero", 32'(pxl), 32'h0);

    for (int v = 0; v < 11; v++) begin
      flip = vecs[v].flipv;
      blank(4);
      wr(vecs[v].a0, vecs[v].d0);
      if (vecs[v].nwr > 1) begin
        cyc(vecs[v].gap);
        wr(vecs[v].a1, vecs[v].d1);
      end
      blank(4); run_line(1);
      blank(6); run_line(1);
      check({vecs[v].name, "_pix"}, 32'(disp[vecs[v].chk]), 32'(vecs[v].exp));
      check({vecs[v].name, "_others0"},
            32'(count_nonzero(vecs[v].chk, (vecs[v].nwr > 1) ? vecs[v].a0 : vecs[v].chk)), 32'd0);
    end

    // Timing slot of x=20 is read 370 (20-162 mod 512), then erased
    flip = 1'b0;
    blank(4); wr(9'd20, 14'h1235);
    blank(4); run_line(1); blank(6); run_line(1);
    check("x20_slot370", 32'(slot_val[370]), 32'h1235);
    blank(6); run_line(1);
    check("x20_line3_zero", 32'(disp[20]), 32'h0);
    blank(6); run_line(1);
    check("x20_line4_zero", 32'(disp[20]), 32'h0);

    // Flip: first slot is x=0x1d, then 0x1c; x=100 lands in slot 441
    flip = 1'b1;
    blank(4); wr(9'h01d, 14'h2222); wr(9'h01c, 14'h3333); wr(9'd100, 14'h1111);
    blank(4); run_line(1); blank(6); run_line(1);
    check("flip_slot0", 32'(slot_val[0]), 32'h2222);
    check("flip_slot1", 32'(slot_val[1]), 32'h3333);
    check("flip_slot441", 32'(slot_val[441]), 32'h1111);
    flip = 1'b0;

    // Half-rate pixel enable: pxl must hold between enables
    blank(4); wr(9'h0a2, 14'h1abc); wr(9'h0a3, 14'h2def);
    blank(4); run_line(1); blank(6); run_line(2);
    check("cen_pix_a2", 32'(disp[9'h0a2]), 32'h1abc);
    check("cen_pix_a3", 32'(disp[9'h0a3]), 32'h2def);
    check("cen_hold", 32'(hold_err), 32'd0);

    // Reset in the middle of a line with writes streaming in
    blank(4); wr(9'd90, 14'h1777);
    blank(4);
    LHBL = 1'b1; pxl_cen = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_addr = 9'(200 + i); wr_data = 14'h1005; wr_we = 1'b1;
      cyc(1);
    end
    rst = 1'b1;
    #1;
    check("rst_pxl_async", 32'(pxl), 32'h0);
    wr_we = 1'b0; LHBL = 1'b0;
    cyc(1);
    check("rst_pxl_next", 32'(pxl), 32'h0);
    cyc(2);
    rst = 1'b0;
    blank(3); wr(9'd80, 14'h2468);
    blank(4); run_line(1); blank(6); run_line(1);
    check("post_rst_line2", 32'(disp[80]), 32'h2468);
    blank(6); run_line(1);
    check("post_rst_line3_clean", 32'(count_nonzero(9'd0, 9'd0) + ((disp[0] !== 14'd0) ? 1 : 0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
